// File: rtl/regfile_xfer_ctrl.sv
// Register file transfer sequencer: LDI/MOV/RD/NOP over a shared tri-state bus
// with setup/strobe/hold write timing and a one-cycle completion pulse.
module regfile_xfer_ctrl #(
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 4,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_src,
  input  logic [IDX_W-1:0]  cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic [IDX_W-1:0]  rf_index,
  output logic              rf_rEn,
  output logic              rf_wEn,
  inout  wire  [DATA_W-1:0] bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SRC,
    S_WR_SETUP,
    S_WR_STROBE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          op_q;
  logic [IDX_W-1:0]    dst_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                cmd_err;
  logic                accept;
  logic                drive_en;

  function automatic logic bad_idx(input logic [IDX_W-1:0] i);
    return 32'(i) >= 32'(NUM_REGS);
  endfunction

  // Only the index fields the opcode actually uses are checked.
  always_comb begin
    cmd_err = 1'b0;
    unique case (cmd_op)
      OP_LDI:  cmd_err = bad_idx(cmd_dst);
      OP_MOV:  cmd_err = bad_idx(cmd_src) | bad_idx(cmd_dst);
      OP_RD:   cmd_err = bad_idx(cmd_src);
      default: cmd_err = 1'b0;
    endcase
  end

  assign accept = cmd_valid && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_err || cmd_op == OP_NOP)
            state_d = S_DONE;
          else if (cmd_op == OP_LDI)
            state_d = S_WR_SETUP;
          else
            state_d = S_RD_SRC;
        end
      end
      S_RD_SRC:
        state_d = (op_q == OP_RD) ? S_DONE : S_WR_SETUP;
      S_WR_SETUP:  state_d = S_WR_STROBE;
      S_WR_STROBE: state_d = S_WR_HOLD;
      S_WR_HOLD:   state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      dst_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= cmd_op;
        dst_q <= cmd_dst;
        err_q <= cmd_err;
        if (cmd_op == OP_LDI)
          data_q <= cmd_imm;
      end
      if (state_q == S_RD_SRC)
        data_q <= bus;
      if (state_q == S_IDLE && state_d == S_RD_SRC)
        idx_q <= cmd_src;
      if (state_d == S_WR_SETUP)
        idx_q <= (state_q == S_IDLE) ? cmd_dst : dst_q;
      // Entering DONE straight from IDLE means NOP or error: keep old data.
      if (state_d == S_DONE && state_q != S_IDLE)
        rsp_data_q <= (state_q == S_RD_SRC) ? bus : data_q;
    end
  end

  assign drive_en  = (state_q == S_WR_SETUP) ||
                     (state_q == S_WR_STROBE) ||
                     (state_q == S_WR_HOLD);
  assign bus       = drive_en ? data_q : {DATA_W{1'bz}};
  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_data  = rsp_data_q;
  assign rf_index  = idx_q;
  assign rf_rEn    = (state_q == S_RD_SRC);
  assign rf_wEn    = (state_q == S_WR_STROBE);

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Directed bench for regfile_xfer_ctrl with a behavioural 4x16 register file
// on the shared bus and monitors for strobe timing and bus contention.
module tb_regfile_xfer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_src;
  logic [3:0]  cmd_dst;
  logic [15:0] cmd_imm;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic [3:0]  rf_index;
  logic        rf_rEn;
  logic        rf_wEn;
  wire  [15:0] bus;

  logic [15:0] rf [4];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int rsp_cnt  = 0;
  int conflict = 0;
  int stab_err = 0;

  logic        pw;
  logic [3:0]  pi;
  logic [15:0] pb;

  regfile_xfer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_imm   (cmd_imm),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .rf_index  (rf_index),
    .rf_rEn    (rf_rEn),
    .rf_wEn    (rf_wEn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  assign bus = rf_rEn ? rf[rf_index[1:0]] : 16'bz;

  always @(posedge rf_wEn) begin
    rf[rf_index[1:0]] <= bus;
    wr_cnt++;
  end

  always @(negedge clk) begin
    if (rf_rEn) rd_cnt++;
    if (rsp_valid) rsp_cnt++;
    if (rf_rEn && dut.drive_en) conflict++;
  end

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      pw <= 1'b0;
    end else begin
      if (rf_wEn && !pw && (rf_index != pi || bus != pb))
        stab_err++;
      if (!rf_wEn && pw && (rf_index != pi || bus != pb))
        stab_err++;
      pw <= rf_wEn;
      pi <= rf_index;
      pb <= bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [3:0] src,
                         input logic [3:0] dst, input logic [15:0] imm);
    cmd_op  = op;
    cmd_src = src;
    cmd_dst = dst;
    cmd_imm = imm;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] src,
                       input logic [3:0] dst, input logic [15:0] imm);
    @(negedge clk);
    wait_ready();
    set_cmd(op, src, dst, imm);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic err,
                          output logic [15:0] data);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    err  = rsp_err;
    data = rsp_data;
  endtask

  task automatic run(input string tag, input logic [1:0] op,
                     input logic [3:0] src, input logic [3:0] dst,
                     input logic [15:0] imm, input int exp_lat,
                     input logic exp_err, input logic [15:0] exp_data);
    int          lat;
    logic        err;
    logic [15:0] data;
    issue(op, src, dst, imm);
    wait_rsp(lat, err, data);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_data"}, 32'(data), 32'(exp_data));
  endtask

  int          lat;
  logic        err;
  logic [15:0] data;
  int          w0, r0, c0;
  logic [15:0] d0;
  int          exp_lat [3] = '{4, 2, 5};

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    set_cmd(2'b00, 4'd0, 4'd0, 16'h0);
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_ren", 32'(rf_rEn), 0);
    check("rst_wen", 32'(rf_wEn), 0);
    check("rst_index", 32'(rf_index), 0);
    check("rst_data", 32'(rsp_data), 0);
    check("rst_drive", 32'(dut.drive_en), 0);
    reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("idle_rst_wen", 32'(rf_wEn), 0);
    check("idle_rst_valid", 32'(rsp_valid), 0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_rst_ready", 32'(cmd_ready), 1);

    w0 = wr_cnt;
    run("ldi2", 2'b01, 4'd0, 4'd2, 16'hA5A5, 4, 1'b0, 16'hA5A5);
    check("ldi2_wedges", 32'(wr_cnt - w0), 1);
    check("ldi2_rf", 32'(rf[2]), 32'hA5A5);
    run("rd2", 2'b11, 4'd2, 4'd0, 16'h0, 2, 1'b0, 16'hA5A5);

    run("mov23", 2'b10, 4'd2, 4'd3, 16'h1111, 5, 1'b0, 16'hA5A5);
    run("rd3", 2'b11, 4'd3, 4'd0, 16'h0, 2, 1'b0, 16'hA5A5);

    issue(2'b11, 4'd2, 4'd0, 16'h0);
    @(negedge clk);
    check("rdsrc_ren", 32'(rf_rEn), 1);
    check("rdsrc_index", 32'(rf_index), 2);
    #1 reset = 1'b1;
    #1;
    check("rdsrc_rst_ren", 32'(rf_rEn), 0);
    check("rdsrc_rst_index", 32'(rf_index), 0);
    check("rdsrc_rst_data", 32'(rsp_data), 0);
    check("rdsrc_rst_drive", 32'(dut.drive_en), 0);
    c0 = rsp_cnt;
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rdsrc_rst_norsp", 32'(rsp_cnt - c0), 0);
    check("rdsrc_rst_ready", 32'(cmd_ready), 1);

    c0 = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    set_cmd(2'b01, 4'd3, 4'd0, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      @(posedge clk);
      #1;
      if (i == 0) set_cmd(2'b11, 4'd0, 4'd2, 16'hFFFF);
      else if (i == 1) set_cmd(2'b10, 4'd0, 4'd1, 16'hEEEE);
      else cmd_valid = 1'b0;
      wait_rsp(lat, err, data);
      check("b2b_lat", 32'(lat), 32'(exp_lat[i]));
      check("b2b_data", 32'(data), 32'h1234);
      @(negedge clk);
      check("b2b_ready", 32'(cmd_ready), 1);
    end
    repeat (3) @(negedge clk);
    check("b2b_count", 32'(rsp_cnt - c0), 3);
    run("b2b_rd1", 2'b11, 4'd1, 4'd0, 16'h0, 2, 1'b0, 16'h1234);

    d0 = rsp_data;
    r0 = rd_cnt;
    w0 = wr_cnt;
    run("err_ldi5", 2'b01, 4'd0, 4'd5, 16'hDEAD, 1, 1'b1, d0);
    run("err_rd4", 2'b11, 4'd4, 4'd0, 16'h0, 1, 1'b1, d0);
    run("err_mov", 2'b10, 4'd0, 4'd9, 16'h0, 1, 1'b1, d0);
    run("nop", 2'b00, 4'd7, 4'd8, 16'hCAFE, 1, 1'b0, d0);
    check("err_no_ren", 32'(rd_cnt - r0), 0);
    check("err_no_wen", 32'(wr_cnt - w0), 0);

    run("ldi0", 2'b01, 4'd0, 4'd0, 16'h0F0F, 4, 1'b0, 16'h0F0F);
    w0 = wr_cnt;
    issue(2'b10, 4'd0, 4'd1, 16'h0);
    repeat (3) @(negedge clk);
    check("strobe_wen", 32'(rf_wEn), 1);
    #1 reset = 1'b1;
    #1;
    check("strobe_rst_wen", 32'(rf_wEn), 0);
    check("strobe_rst_drive", 32'(dut.drive_en), 0);
    check("strobe_rst_valid", 32'(rsp_valid), 0);
    check("strobe_rf1", 32'(rf[1]), 32'h0F0F);
    c0 = rsp_cnt;
    #2 reset = 1'b0;
    repeat (6) @(negedge clk);
    check("strobe_norsp", 32'(rsp_cnt - c0), 0);
    check("strobe_wedges", 32'(wr_cnt - w0), 1);
    run("post_ldi3", 2'b01, 4'd0, 4'd3, 16'hBEEF, 4, 1'b0, 16'hBEEF);
    run("post_rd3", 2'b11, 4'd3, 4'd0, 16'h0, 2, 1'b0, 16'hBEEF);

    check("bus_conflict", 32'(conflict), 0);
    check("wen_stability", 32'(stab_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
